// File: rtl/simd_mac_accumulator_32bits.sv
// Merges SIMD multiplier result pairs into lane-packed products and accumulates them per first..last window (SIMD_ACC_SATURATE_EN: saturating lanes + sat_flag).
// Latency: triple accepted with in_last at cycle t -> out_valid at t+2; one sample per cycle otherwise.
// Backpressure: in_ready drops while an emitted word waits for out_ready; both stages then hold.
module simd_mac_accumulator_32bits #(
    parameter int GUARD = 4,
    parameter int CNT_W = 16,
    localparam int ACC_W = 32 + 8 * GUARD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [1:0]       in_mode,
    input  logic             in_sign,
    input  logic [31:0]      in_result_0,
    input  logic [31:0]      in_result_1,
    input  logic [7:0]       in_simd_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] acc_count,
    output logic [7:0]       carry_flags,
    output logic             mode_err
`ifdef SIMD_ACC_SATURATE_EN
    ,
    output logic             sat_flag
`endif
);
    localparam int LMAX = 32 + GUARD;
    typedef logic [LMAX:0] lane_t;

    logic             r_win_open;
    logic [1:0]       r_win_mode;
    logic             r_s1_vld, r_s1_first, r_s1_last, r_s1_sign, r_s1_merr;
    logic [1:0]       r_s1_mode;
    logic [31:0]      r_s1_p;
    logic [7:0]       r_s1_carry;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_cflags;
    logic             r_merr;
    logic             r_out_vld;
    logic [ACC_W-1:0] r_out_acc;
    logic [CNT_W-1:0] r_out_cnt;
    logic [7:0]       r_out_cflags;
    logic             r_out_merr;

    logic             w_eff_first, w_mode_err, w_s2_adv;
    logic [1:0]       w_eff_mode;
    logic [31:0]      w_p;
    logic [ACC_W-1:0] w_acc_wrap, w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       w_cflags_nxt;
    logic             w_merr_nxt;

    // One accumulator update for n lanes of lw product bits, each lane lw+GUARD wide.
    function automatic logic [ACC_W-1:0] acc_lanes(
        input logic [ACC_W-1:0] acc, input logic [31:0] p, input int n, input int lw,
        input logic sgn, input logic first, input logic sat);
        int               w;
        lane_t            wmask, lmask, top, a, b, s, res;
        logic             sa, ovf;
        logic [ACC_W-1:0] out;
        w     = lw + GUARD;
        wmask = (lane_t'(1) << w) - lane_t'(1);
        lmask = (lane_t'(1) << lw) - lane_t'(1);
        top   = lane_t'(1) << (w - 1);
        out   = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                b = lane_t'(p >> (i * lw)) & lmask;
                if (sgn && ((b & (lane_t'(1) << (lw - 1))) != '0))
                    b = b | (wmask & ~lmask);
                a  = lane_t'(acc >> (i * w)) & wmask;
                s  = a + b;
                sa = (a & top) != '0;
                if (sgn)
                    ovf = (sa == ((b & top) != '0)) && (((s & top) != '0) != sa);
                else
                    ovf = (s & ~wmask) != '0;
                res = s & wmask;
                if (first)
                    res = b;
                else if (sat && ovf)
                    res = sgn ? (sa ? top : (wmask >> 1)) : wmask;
                out = out | (ACC_W'(res) << (i * w));
            end
        end
        return out;
    endfunction

    function automatic logic [ACC_W-1:0] merge_mode(
        input logic [ACC_W-1:0] acc, input logic [31:0] p, input logic [1:0] mode,
        input logic sgn, input logic first, input logic sat);
        logic [ACC_W-1:0] v;
        case (mode)
            2'b00: begin
                v = acc_lanes(acc, p, 1, 32, sgn, first, sat);
                v[ACC_W-1:LMAX] = {(ACC_W - LMAX){v[LMAX-1]}};
            end
            2'b01:   v = acc_lanes(acc, p, 2, 16, sgn, first, sat);
            2'b10:   v = acc_lanes(acc, p, 4, 8, sgn, first, sat);
            default: v = acc_lanes(acc, p, 8, 4, sgn, first, sat);
        endcase
        return v;
    endfunction

    assign in_ready = !(r_out_vld && !out_ready);

    // Window tracking lives in stage 1 so a mismatched sample is merged in the latched layout.
    assign w_eff_first = in_first || !r_win_open;
    assign w_eff_mode  = w_eff_first ? in_mode : r_win_mode;
    assign w_mode_err  = !w_eff_first && (in_mode != r_win_mode);

    always_comb begin
        w_p = '0;
        case (w_eff_mode)
            2'b00: w_p = in_result_0 + in_result_1;
            2'b01: for (int i = 0; i < 2; i++)
                w_p[i*16 +: 16] = in_result_0[i*16 +: 16] + in_result_1[i*16 +: 16];
            2'b10: for (int i = 0; i < 4; i++)
                w_p[i*8 +: 8] = in_result_0[i*8 +: 8] + in_result_1[i*8 +: 8];
            default: for (int i = 0; i < 8; i++)
                w_p[i*4 +: 4] = in_result_0[i*4 +: 4] + in_result_1[i*4 +: 4];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_open <= 1'b0;
            r_win_mode <= 2'b00;
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_merr  <= 1'b0;
            r_s1_mode  <= 2'b00;
            r_s1_p     <= '0;
            r_s1_carry <= '0;
        end else if (in_ready) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_win_open <= !in_last;
                if (w_eff_first)
                    r_win_mode <= in_mode;
                r_s1_first <= w_eff_first;
                r_s1_last  <= in_last;
                r_s1_sign  <= in_sign;
                r_s1_merr  <= w_mode_err;
                r_s1_mode  <= w_eff_mode;
                r_s1_p     <= w_p;
                r_s1_carry <= in_simd_carry;
            end
        end
    end

    assign w_s2_adv     = in_ready && r_s1_vld;
    assign w_acc_wrap   = merge_mode(r_acc, r_s1_p, r_s1_mode, r_s1_sign, r_s1_first, 1'b0);
    assign w_cnt_nxt    = r_s1_first ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
    assign w_cflags_nxt = r_s1_first ? r_s1_carry : (r_cflags | r_s1_carry);
    assign w_merr_nxt   = !r_s1_first && (r_merr || r_s1_merr);

`ifdef SIMD_ACC_SATURATE_EN
    logic [ACC_W-1:0] w_acc_sat;
    logic             w_sat_hit, w_sat_nxt, r_sat, r_out_sat;
    assign w_acc_sat = merge_mode(r_acc, r_s1_p, r_s1_mode, r_s1_sign, r_s1_first, 1'b1);
    // A clamped lane is the only way the saturating and wrapping sums can differ.
    assign w_sat_hit = (w_acc_sat != w_acc_wrap);
    assign w_sat_nxt = (!r_s1_first && r_sat) || w_sat_hit;
    assign w_acc_nxt = w_acc_sat;
    assign sat_flag  = r_out_sat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat     <= 1'b0;
            r_out_sat <= 1'b0;
        end else if (w_s2_adv) begin
            r_sat <= w_sat_nxt;
            if (r_s1_last)
                r_out_sat <= w_sat_nxt;
        end
    end
`else
    assign w_acc_nxt = w_acc_wrap;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_cflags <= '0;
            r_merr   <= 1'b0;
        end else if (w_s2_adv) begin
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cflags <= w_cflags_nxt;
            r_merr   <= w_merr_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_vld    <= 1'b0;
            r_out_acc    <= '0;
            r_out_cnt    <= '0;
            r_out_cflags <= '0;
            r_out_merr   <= 1'b0;
        end else if (w_s2_adv && r_s1_last) begin
            r_out_vld    <= 1'b1;
            r_out_acc    <= w_acc_nxt;
            r_out_cnt    <= w_cnt_nxt;
            r_out_cflags <= w_cflags_nxt;
            r_out_merr   <= w_merr_nxt;
        end else if (out_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    assign out_valid   = r_out_vld;
    assign acc_out     = r_out_acc;
    assign acc_count   = r_out_cnt;
    assign carry_flags = r_out_cflags;
    assign mode_err    = r_out_merr;

endmodule
